// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect
// Multi-channel input conditioner: synchronises raw asynchronous inputs,
// debounces each channel with a timed four-state machine clocked by a shared
// prescaler strobe, and presents registered levels plus one-cycle rise/fall
// pulses for downstream controller next-state logic.
module debounce_edge_detect #(
    parameter int N_CH        = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DB_TICKS    = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_TO_HIGH,
        ST_HIGH,
        ST_TO_LOW
    } db_state_e;

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] s;

    // Shift din through the synchroniser stages with no logic in between
    always_comb begin
        sync_d[0] = din;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Synchroniser flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    // Wrap counter at CLK_DIV-1; tick is looked up from the next count so the
    // registered strobe lines up with the cycle the counter holds CLK_DIV-1
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PRESC_LAST);
    end

    // Prescaler registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    // ------------------------------------------------------------------
    // Per-channel debounce FSMs
    // ------------------------------------------------------------------
    db_state_e       state_q [N_CH];
    db_state_e       state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q,  rise_d;
    logic [N_CH-1:0] fall_q,  fall_d;

    // Next-state, qualification counter and registered-output inputs per channel
    always_comb begin
        level_d = '0;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            unique case (state_q[ch])
                ST_LOW: begin
                    if (s[ch]) begin
                        state_d[ch] = ST_TO_HIGH;
                        cnt_d[ch]   = '0;
                    end
                end
                ST_TO_HIGH: begin
                    // Abort is tested first so it wins over a coincident final tick
                    if (!s[ch]) begin
                        state_d[ch] = ST_LOW;
                        cnt_d[ch]   = '0;
                    end else if (tick_q) begin
                        if (cnt_q[ch] == CNT_LAST) begin
                            state_d[ch] = ST_HIGH;
                            cnt_d[ch]   = '0;
                            rise_d[ch]  = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CW'(1);
                        end
                    end
                end
                ST_HIGH: begin
                    if (!s[ch]) begin
                        state_d[ch] = ST_TO_LOW;
                        cnt_d[ch]   = '0;
                    end
                end
                ST_TO_LOW: begin
                    if (s[ch]) begin
                        state_d[ch] = ST_HIGH;
                        cnt_d[ch]   = '0;
                    end else if (tick_q) begin
                        if (cnt_q[ch] == CNT_LAST) begin
                            state_d[ch] = ST_LOW;
                            cnt_d[ch]   = '0;
                            fall_d[ch]  = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[ch] = ST_LOW;
                    cnt_d[ch]   = '0;
                end
            endcase
            // Level decoded from the next state so it commits on the same edge
            level_d[ch] = (state_d[ch] == ST_HIGH) || (state_d[ch] == ST_TO_LOW);
        end
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= ST_LOW;
                cnt_q[ch]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
